// File: rtl/mud_feedback_pkg.sv
// mud_feedback_pkg
// Shared definitions for the multi-channel feedback enable/pulse array:
// per-channel FSM state encoding, default parameter values and the
// synchroniser depth floor. No ports.
package mud_feedback_pkg;

  localparam int NCH_DEF         = 4;
  localparam int PULSE_W_DEF     = 8;
  localparam int TIMEOUT_W_DEF   = 12;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_STAGES_MIN = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PULSE   = 3'd1,
    ST_WAIT_OK = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  // A requested depth below the floor would not be metastability-safe.
  function automatic int sync_depth(input int req);
    return (req < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : req;
  endfunction

endpackage

// File: rtl/mud_feedback_pulse_chan.sv
// mud_feedback_pulse_chan
// One feedback channel: registers the enable request, detects its rising
// edge, issues a programmable-length start pulse, synchronises the returning
// ok indication and (with MUD_FEEDBACK_TIMEOUT_EN defined) raises a sticky
// fault if ok does not arrive within timeout_cycles_i.
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   enable_feedback_i   enable request
//   ok_feedback_i       asynchronous loop-settled indication
//   pulse_len_i         pulse length, 0 = hold pulse until ok
//   timeout_cycles_i    cycles from pulse start to fault, 0 = disabled
//   fault_clr_i         fault clear (honoured only with enable low)
//   enable_o, pulse_o, ok_sync_o, fault_o   registered outputs
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | waiting for an enable rising edge
// PULSE    | start pulse asserted, counting pulse length
// WAIT_OK  | pulse finished, waiting for ok_sync
// DONE     | loop settled, held until enable drops
// FAULT    | ok timed out; sticky until fault_clr with enable low
module mud_feedback_pulse_chan
  import mud_feedback_pkg::*;
#(
  parameter int PULSE_W     = PULSE_W_DEF,
  parameter int TIMEOUT_W   = TIMEOUT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_feedback_i,
  input  logic                 ok_feedback_i,
  input  logic [PULSE_W-1:0]   pulse_len_i,
  input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
  input  logic                 fault_clr_i,
  output logic                 enable_o,
  output logic                 pulse_o,
  output logic                 ok_sync_o,
  output logic                 fault_o
);

  localparam int SYNC_N = sync_depth(SYNC_STAGES);

  state_e             state_q, state_d;
  logic               en_q, en_dly_q;
  logic [SYNC_N-1:0]  sync_q;
  logic [PULSE_W-1:0] plen_q, plen_d;
  logic               pulse_q;
  logic               rise, ok_s;

  assign ok_s = sync_q[SYNC_N-1];
  assign rise = en_q & ~en_dly_q;

`ifdef MUD_FEEDBACK_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d, tmo_inc, tmo_sat;
  logic                 tmo_hit;
  logic                 fault_q;

  assign tmo_inc = tmo_q + 1'b1;
  // Saturated counter never wraps back onto a small timeout value.
  assign tmo_sat = (&tmo_q) ? tmo_q : tmo_inc;
  assign tmo_hit = (timeout_cycles_i != '0) && (tmo_inc == timeout_cycles_i);
`else
  logic unused_tmo_ports;
  assign unused_tmo_ports = ^{timeout_cycles_i, fault_clr_i};
`endif

  always_comb begin
    state_d = state_q;
    plen_d  = plen_q;
`ifdef MUD_FEEDBACK_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_PULSE;
          plen_d  = pulse_len_i;
`ifdef MUD_FEEDBACK_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      ST_PULSE: begin
`ifdef MUD_FEEDBACK_TIMEOUT_EN
        tmo_d = tmo_sat;
`endif
        if (!en_q)                      state_d = ST_IDLE;
        else if (ok_s)                  state_d = ST_DONE;
`ifdef MUD_FEEDBACK_TIMEOUT_EN
        else if (tmo_hit)               state_d = ST_FAULT;
`endif
        else if (plen_q == PULSE_W'(1)) state_d = ST_WAIT_OK;
        // plen_q of 0 marks legacy mode: hold the pulse until ok.
        else if (plen_q != '0)          plen_d  = plen_q - 1'b1;
      end
      ST_WAIT_OK: begin
`ifdef MUD_FEEDBACK_TIMEOUT_EN
        tmo_d = tmo_sat;
`endif
        if (!en_q)        state_d = ST_IDLE;
        else if (ok_s)    state_d = ST_DONE;
`ifdef MUD_FEEDBACK_TIMEOUT_EN
        else if (tmo_hit) state_d = ST_FAULT;
`endif
      end
      ST_DONE: begin
        if (!en_q) state_d = ST_IDLE;
      end
`ifdef MUD_FEEDBACK_TIMEOUT_EN
      ST_FAULT: begin
        if (fault_clr_i && !en_q) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      en_dly_q <= 1'b0;
      sync_q   <= '0;
      plen_q   <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= enable_feedback_i;
      en_dly_q <= en_q;
      sync_q   <= {sync_q[SYNC_N-2:0], ok_feedback_i};
      plen_q   <= plen_d;
      pulse_q  <= (state_q == ST_PULSE);
    end
  end

`ifdef MUD_FEEDBACK_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      fault_q <= (state_q == ST_FAULT);
    end
  end
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

  assign enable_o  = en_q;
  assign pulse_o   = pulse_q;
  assign ok_sync_o = ok_s;

endmodule

// File: rtl/mud_feedback_pulse_array.sv
// mud_feedback_pulse_array
// NCH independent feedback enable/pulse channels between the sequencer and
// the analog loop cells. pulse_len_i and timeout_cycles_i are shared by all
// channels. Optional timeout/fault logic: define MUD_FEEDBACK_TIMEOUT_EN.
// Ports:
//   clk_i, rst_n_i       clock, synchronous active-low reset
//   enable_feedback_i    [NCH] enable requests
//   ok_feedback_i        [NCH] asynchronous loop-settled indications
//   pulse_len_i          [PULSE_W] pulse length (0 = hold until ok)
//   timeout_cycles_i     [TIMEOUT_W] timeout (0 = disabled)
//   fault_clr_i          [NCH] fault clears
//   enable_o, pulse_o, ok_sync_o, fault_o   [NCH] per-channel outputs
module mud_feedback_pulse_array
  import mud_feedback_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int PULSE_W     = PULSE_W_DEF,
  parameter int TIMEOUT_W   = TIMEOUT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NCH-1:0]       enable_feedback_i,
  input  logic [NCH-1:0]       ok_feedback_i,
  input  logic [PULSE_W-1:0]   pulse_len_i,
  input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
  input  logic [NCH-1:0]       fault_clr_i,
  output logic [NCH-1:0]       enable_o,
  output logic [NCH-1:0]       pulse_o,
  output logic [NCH-1:0]       ok_sync_o,
  output logic [NCH-1:0]       fault_o
);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    mud_feedback_pulse_chan #(
      .PULSE_W     (PULSE_W),
      .TIMEOUT_W   (TIMEOUT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .enable_feedback_i (enable_feedback_i[g]),
      .ok_feedback_i     (ok_feedback_i[g]),
      .pulse_len_i       (pulse_len_i),
      .timeout_cycles_i  (timeout_cycles_i),
      .fault_clr_i       (fault_clr_i[g]),
      .enable_o          (enable_o[g]),
      .pulse_o           (pulse_o[g]),
      .ok_sync_o         (ok_sync_o[g]),
      .fault_o           (fault_o[g])
    );
  end

endmodule

// File: tb/tb_mud_feedback_pulse_array.sv
// Directed bench for mud_feedback_pulse_array. Cycle n is the interval after
// the n-th rising edge counted from the cycle where the stimulus is applied.
module tb_mud_feedback_pulse_array;
  import mud_feedback_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [3:0]  ef = '0;
  logic [3:0]  okf = '0;
  logic [3:0]  fclr = '0;
  logic [7:0]  plen = '0;
  logic [11:0] tmo = '0;
  logic [3:0]  en_o, pulse_o, ok_sync_o, fault_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mud_feedback_pulse_array #(
    .NCH(4), .PULSE_W(8), .TIMEOUT_W(12), .SYNC_STAGES(2)
  ) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .enable_feedback_i (ef),
    .ok_feedback_i     (okf),
    .pulse_len_i       (plen),
    .timeout_cycles_i  (tmo),
    .fault_clr_i       (fclr),
    .enable_o          (en_o),
    .pulse_o           (pulse_o),
    .ok_sync_o         (ok_sync_o),
    .fault_o           (fault_o)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    ef = '0; okf = '0; fclr = '0;
    tick(2);
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    ef = 4'hF; okf = 4'hF;
    tick(3);
    checks++;
    if ({en_o, pulse_o, ok_sync_o, fault_o} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0000", {en_o, pulse_o, ok_sync_o, fault_o});
    end
    checks++;
    if (dut.g_chan[0].u_chan.state_q !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state0 got=%0d exp=%0d", dut.g_chan[0].u_chan.state_q, ST_IDLE);
    end
    ef = '0; okf = '0;
  endtask

  task automatic test_basic_pulse();
    logic e;
    do_reset();
    plen = 8'd4; tmo = 12'd0;
    ef[0] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      if (c == 1) begin
        checks++;
        if (en_o[0] !== 1'b1) begin
          failures++;
          $display("FAIL basic_enable got=%b exp=1", en_o[0]);
        end
      end
      e = (c >= 3 && c <= 6);
      checks++;
      if (pulse_o !== {3'b000, e}) begin
        failures++;
        $display("FAIL basic_pulse cycle=%0d got=%b exp=%b", c, pulse_o, {3'b000, e});
      end
    end
    checks++;
    if (dut.g_chan[0].u_chan.state_q !== ST_WAIT_OK) begin
      failures++;
      $display("FAIL basic_state got=%0d exp=%0d", dut.g_chan[0].u_chan.state_q, ST_WAIT_OK);
    end
    checks++;
    if (fault_o !== 4'h0) begin
      failures++;
      $display("FAIL basic_fault got=%b exp=0000", fault_o);
    end
  endtask

  task automatic test_legacy_stop();
    logic e;
    do_reset();
    plen = 8'd0; tmo = 12'd0;
    ef[1] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick(1);
      e = (c >= 3 && c <= 13);
      checks++;
      if (pulse_o[1] !== e) begin
        failures++;
        $display("FAIL legacy_pulse cycle=%0d got=%b exp=%b", c, pulse_o[1], e);
      end
      e = (c >= 12);
      checks++;
      if (ok_sync_o[1] !== e) begin
        failures++;
        $display("FAIL legacy_ok_sync cycle=%0d got=%b exp=%b", c, ok_sync_o[1], e);
      end
      if (c == 10) okf[1] = 1'b1;
    end
    checks++;
    if (dut.g_chan[1].u_chan.state_q !== ST_DONE) begin
      failures++;
      $display("FAIL legacy_state got=%0d exp=%0d", dut.g_chan[1].u_chan.state_q, ST_DONE);
    end
    ef[1] = 1'b0;
    tick(2);
    checks++;
    if (dut.g_chan[1].u_chan.state_q !== ST_IDLE) begin
      failures++;
      $display("FAIL legacy_release got=%0d exp=%0d", dut.g_chan[1].u_chan.state_q, ST_IDLE);
    end
  endtask

  task automatic test_ok_early();
    logic e;
    do_reset();
    plen = 8'd4; tmo = 12'd0;
    okf[0] = 1'b1;
    tick(4);
    ef[0] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick(1);
      e = (c == 3);
      checks++;
      if (pulse_o[0] !== e) begin
        failures++;
        $display("FAIL ok_early_pulse cycle=%0d got=%b exp=%b", c, pulse_o[0], e);
      end
    end
    checks++;
    if (dut.g_chan[0].u_chan.state_q !== ST_DONE) begin
      failures++;
      $display("FAIL ok_early_state got=%0d exp=%0d", dut.g_chan[0].u_chan.state_q, ST_DONE);
    end
  endtask

  task automatic test_abort();
    logic e;
    do_reset();
    plen = 8'd6; tmo = 12'd0;
    ef[0] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      e = (c >= 3 && c <= 6);
      checks++;
      if (pulse_o[0] !== e) begin
        failures++;
        $display("FAIL abort_pulse cycle=%0d got=%b exp=%b", c, pulse_o[0], e);
      end
      if (c == 4) ef[0] = 1'b0;
    end
    checks++;
    if (dut.g_chan[0].u_chan.state_q !== ST_IDLE) begin
      failures++;
      $display("FAIL abort_state got=%0d exp=%0d", dut.g_chan[0].u_chan.state_q, ST_IDLE);
    end
    ef[0] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      e = (c >= 3 && c <= 8);
      checks++;
      if (pulse_o[0] !== e) begin
        failures++;
        $display("FAIL abort_restart cycle=%0d got=%b exp=%b", c, pulse_o[0], e);
      end
    end
  endtask

`ifdef MUD_FEEDBACK_TIMEOUT_EN
  task automatic test_timeout();
    logic e;
    do_reset();
    plen = 8'd2; tmo = 12'd20;
    ef[2] = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick(1);
      e = (c >= 23);
      checks++;
      if (fault_o[2] !== e) begin
        failures++;
        $display("FAIL timeout_fault cycle=%0d got=%b exp=%b", c, fault_o[2], e);
      end
      e = (c >= 3 && c <= 4);
      checks++;
      if (pulse_o[2] !== e) begin
        failures++;
        $display("FAIL timeout_pulse cycle=%0d got=%b exp=%b", c, pulse_o[2], e);
      end
    end
    fclr[2] = 1'b1;
    tick(2);
    fclr[2] = 1'b0;
    checks++;
    if (fault_o[2] !== 1'b1) begin
      failures++;
      $display("FAIL timeout_clr_enabled got=%b exp=1", fault_o[2]);
    end
    ef[2] = 1'b0;
    tick(3);
    checks++;
    if (fault_o[2] !== 1'b1) begin
      failures++;
      $display("FAIL timeout_enable_fall got=%b exp=1", fault_o[2]);
    end
    ef[2] = 1'b1;
    tick(4);
    checks++;
    if (dut.g_chan[2].u_chan.state_q !== ST_FAULT || pulse_o[2] !== 1'b0) begin
      failures++;
      $display("FAIL timeout_rise_ignored state=%0d pulse=%b exp state=%0d pulse=0",
               dut.g_chan[2].u_chan.state_q, pulse_o[2], ST_FAULT);
    end
    ef[2] = 1'b0;
    tick(2);
    fclr[2] = 1'b1;
    tick(1);
    fclr[2] = 1'b0;
    checks++;
    if (dut.g_chan[2].u_chan.state_q !== ST_IDLE) begin
      failures++;
      $display("FAIL timeout_clear_state got=%0d exp=%0d", dut.g_chan[2].u_chan.state_q, ST_IDLE);
    end
    tick(1);
    checks++;
    if (fault_o[2] !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear_fault got=%b exp=0", fault_o[2]);
    end
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    plen = 8'd2; tmo = 12'd5;
    ef[2] = 1'b1;
    tick(20);
    fclr[2] = 1'b1;
    tick(20);
    fclr[2] = 1'b0;
    checks++;
    if (dut.g_chan[2].u_chan.state_q !== ST_WAIT_OK) begin
      failures++;
      $display("FAIL no_timeout_state got=%0d exp=%0d", dut.g_chan[2].u_chan.state_q, ST_WAIT_OK);
    end
    checks++;
    if (fault_o !== 4'h0) begin
      failures++;
      $display("FAIL no_timeout_fault got=%b exp=0000", fault_o);
    end
  endtask
`endif

  task automatic test_ok_vs_timeout();
    do_reset();
    plen = 8'd2; tmo = 12'd20;
    ef[3] = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      tick(1);
      checks++;
      if (fault_o[3] !== 1'b0) begin
        failures++;
        $display("FAIL ok_vs_timeout_fault cycle=%0d got=%b exp=0", c, fault_o[3]);
      end
      if (c == 19) okf[3] = 1'b1;
    end
    checks++;
    if (dut.g_chan[3].u_chan.state_q !== ST_DONE) begin
      failures++;
      $display("FAIL ok_vs_timeout_state got=%0d exp=%0d", dut.g_chan[3].u_chan.state_q, ST_DONE);
    end
  endtask

  task automatic test_reset_channels();
    logic [3:0] e;
    do_reset();
    plen = 8'd10; tmo = 12'd0;
    ef = 4'hF;
    tick(4);
    checks++;
    if (pulse_o !== 4'hF) begin
      failures++;
      $display("FAIL midrun_pulse got=%b exp=1111", pulse_o);
    end
    rst_n_i = 1'b0;
    tick(1);
    checks++;
    if ({en_o, pulse_o, ok_sync_o, fault_o} !== 16'h0) begin
      failures++;
      $display("FAIL midrun_reset got=%h exp=0000", {en_o, pulse_o, ok_sync_o, fault_o});
    end
    checks++;
    if (dut.g_chan[3].u_chan.state_q !== ST_IDLE) begin
      failures++;
      $display("FAIL midrun_reset_state got=%0d exp=%0d", dut.g_chan[3].u_chan.state_q, ST_IDLE);
    end
    rst_n_i = 1'b1;
    ef = '0;
    plen = 8'd3;
    for (int c = 0; c < 16; c++) begin
      if ((c % 2) == 0 && c < 8) ef[c/2] = 1'b1;
      tick(1);
      e = '0;
      for (int k = 0; k < 4; k++)
        if ((c + 1) >= (2 * k + 3) && (c + 1) <= (2 * k + 5)) e[k] = 1'b1;
      checks++;
      if (pulse_o !== e) begin
        failures++;
        $display("FAIL stagger_pulse cycle=%0d got=%b exp=%b", c + 1, pulse_o, e);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_pulse();
    test_legacy_stop();
    test_ok_early();
    test_abort();
`ifdef MUD_FEEDBACK_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_ok_vs_timeout();
    test_reset_channels();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
